barrett_reduction_q3329: RTL and testbench
==========================================

// Module: barrett_reduction_q3329
// PURPOSE
//   Pipelined modular reducer: result = c mod Q, with Q = 3329 (Kyber prime).
//   Takes a 32-bit unsigned operand, e.g. a butterfly product, and returns the canonical residue in [0, Q-1].
//   Sits in the NTT butterfly unit after the multiplier; streams one operand per cycle, no backpressure.
// PARAMETERS
//   IN_W   32   operand width (unsigned)
//   OUT_W  16   result width; residue zero-extended (bits [15:12] always 0)
// PORTS
//   clk        in   1      single clock, all state on rising edge
//   rst_n      in   1      synchronous active-low reset
//   in_valid   in   1      c is valid this cycle
//   c          in   IN_W   operand, unsigned
//   out_valid  out  1      result valid this cycle
//   result     out  OUT_W  c mod 3329, zero-extended
// BEHAVIOUR
//   - Barrett constants: K = 44, M = floor(2^44/3329) = 5284525696 (33-bit).
//     2^44 - M*Q = 2432 < Q, so the estimate error is at most 1 for all c < 2^32.
//   - S1 (register): capture c and in_valid.
//   - S2 (estimate):
//     - qh = (c*M) >> 44; the 65-bit product is truncated to 21 bits.
//     - The quotient is < 2^21 for all 32-bit c.
//   - S3 (correct):
//     - r = c - qh*Q, computed modulo 2^13; guaranteed 0 <= r < 2Q = 6658.
//     - result = (r >= Q) ? r - Q : r.
//     - Exactly one conditional subtract.
//   - Latency: 3 cycles. A sample with in_valid=1 sampled at edge N gives out_valid=1 at edge N+3, with its result.
//   - Throughput: 1 result per cycle; back-to-back inputs are fully supported.
//   - Valid is a shift chain alongside the data. Gaps in in_valid appear as identical gaps in out_valid.
//   - When out_valid = 0, result holds its last value. Consumers must qualify result with out_valid.
//   - Reset (rst_n = 0 at an edge):
//     - out_valid = 0, result = 0, all pipeline valid bits = 0.
//     - In-flight samples are discarded, including when reset hits mid-stream.
//     - Inputs presented while rst_n = 0 are ignored.
//     - The first input accepted after reset is released appears 3 cycles later.
//   - Arithmetic is unsigned throughout; no overflow is possible at the stated widths.
//   - Edge inputs: c = 0 gives 0. c = 0xFFFFFFFF (maximum) must still give the exact residue, with no extra correction.
//   - Purely functional: no X propagation from c when in_valid = 0. Data regs may load freely; only the valid bits gate.
// STRUCTURE
//   - Shared package ntt_pkg:
//     - localparams Q = 3329, BARRETT_K = 44, BARRETT_M = 33'd5284525696.
//     - typedef coeff_t = logic [15:0].
//   - Sub-module barrett_const_mult: pipelined 32x33 multiply by BARRETT_M returning the top 21 bits.
//     - Optional internal split into partial products, as long as the external latency stays 3 cycles.
//   - Final stage (qh*Q multiply, subtract, conditional subtract) lives inline in the top module.
// TESTING
//   - Reset then single samples: c = 0 -> 0; c = 3328 -> 3328; c = 3329 -> 0; c = 6657 -> 3328; c = 6658 -> 0.
//     Each arrives with out_valid exactly 3 cycles after in_valid.
//   - Extremes: c = 0xFFFFFFFF -> 1352; c = 0x12345678 -> 791; c = 0x00000D02 (3330) -> 1.
//   - Streaming: 1000 random c on consecutive cycles with in_valid held 1.
//     Each result equals c % 3329, in order; out_valid is high for exactly 1000 cycles.
//   - Bubbles: in_valid pattern 1,0,1,1,0 -> identical out_valid pattern delayed 3 cycles.
//     result holds its last value during the gaps.
//   - Reset mid-flight: issue 2 samples, assert rst_n = 0 one cycle later -> out_valid never asserts for them.
//     out_valid = 0 and result = 0 during reset.
//   - Reset held with in_valid = 1 -> no output; release -> a new sample returns after 3 cycles.

Source files
------------

// File: rtl/ntt_pkg.sv
// ntt_pkg
//   Shared constants and types for the NTT datapath.
//   Q            Kyber prime modulus
//   BARRETT_K    Barrett shift amount
//   BARRETT_M    floor(2^K / Q), 33 bits
//   BARRETT_M_LO / BARRETT_M_HI  split of M used by the pipelined multiplier
//   coeff_t      16-bit coefficient container
package ntt_pkg;

    localparam int          Q            = 3329;
    localparam int          BARRETT_K    = 44;
    localparam logic [32:0] BARRETT_M    = 33'd5284525696;

    // M = 0x1_3AFB_7680, split at bit 16 so each partial product stays narrow
    localparam logic [15:0] BARRETT_M_LO = BARRETT_M[15:0];
    localparam logic [16:0] BARRETT_M_HI = BARRETT_M[32:16];

    typedef logic [15:0] coeff_t;

endpackage

// File: rtl/barrett_const_mult.sv
// barrett_const_mult
//   Two-stage pipelined multiply of a 32-bit operand by BARRETT_M, returning
//   the quotient estimate (c*M) >> 44 truncated to 21 bits.
//   Ports:
//     clk  in   1   rising-edge clock
//     c    in   32  operand
//     qh   out  21  quotient estimate, valid two edges after c is presented
//   Data registers carry no reset; validity is tracked by the caller.
module barrett_const_mult
    import ntt_pkg::*;
(
    input  logic        clk,
    input  logic [31:0] c,
    output logic [20:0] qh
);

    logic [47:0] pp_lo;
    logic [48:0] pp_hi;

    // First stage forms the two partial products; the second stage aligns,
    // adds and keeps only the quotient bits above bit 44.
    always_ff @(posedge clk) begin
        pp_lo <= {16'd0, c} * {32'd0, BARRETT_M_LO};
        pp_hi <= {17'd0, c} * {32'd0, BARRETT_M_HI};
        qh    <= 21'(({pp_hi, 16'd0} + {17'd0, pp_lo}) >> BARRETT_K);
    end

endmodule

// File: rtl/barrett_reduction_q3329.sv
// barrett_reduction_q3329
//   Pipelined reducer: result = c mod 3329, canonical residue in [0, Q-1].
//   Streams one operand per cycle, latency 3 cycles, no backpressure.
//   Ports:
//     clk        in   1      rising-edge clock
//     rst_n      in   1      synchronous active-low reset
//     in_valid   in   1      c is valid this cycle
//     c          in   IN_W   unsigned operand
//     out_valid  out  1      result valid this cycle
//     result     out  OUT_W  residue, zero-extended; holds when out_valid = 0
module barrett_reduction_q3329
    import ntt_pkg::*;
#(
    parameter int IN_W  = 32,
    parameter int OUT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [IN_W-1:0]  c,
    output logic             out_valid,
    output logic [OUT_W-1:0] result
);

    localparam logic [12:0] Q13 = 13'(Q);

    logic [IN_W-1:0] c_s1;
    logic            v_s1;
    logic [12:0]     c_lo_s2;
    logic [12:0]     c_lo_s3;
    logic            v_s2;
    logic            v_s3;
    logic [20:0]     qh;
    logic [12:0]     r_raw;
    logic [12:0]     r_corr;

    // Input capture; data loads freely, only the valid bit is reset.
    always_ff @(posedge clk) begin
        c_s1 <= c;
        if (!rst_n) begin
            v_s1 <= 1'b0;
        end else begin
            v_s1 <= in_valid;
        end
    end

    barrett_const_mult u_mult (
        .clk (clk),
        .c   (c_s1),
        .qh  (qh)
    );

    // Only the low 13 bits of c travel alongside the multiplier, since the
    // remainder is known to fit in 13 bits (r < 2Q < 2^13).
    always_ff @(posedge clk) begin
        c_lo_s2 <= c_s1[12:0];
        c_lo_s3 <= c_lo_s2;
        if (!rst_n) begin
            v_s2 <= 1'b0;
            v_s3 <= 1'b0;
        end else begin
            v_s2 <= v_s1;
            v_s3 <= v_s2;
        end
    end

    // The estimate is at most one short, so a single conditional subtract
    // yields the canonical residue.
    always_comb begin
        r_raw  = 13'({8'd0, c_lo_s3} - qh * 21'(Q));
        r_corr = (r_raw >= Q13) ? (r_raw - Q13) : r_raw;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            result    <= '0;
        end else begin
            out_valid <= v_s3;
            if (v_s3) begin
                result <= OUT_W'(r_corr);
            end
        end
    end

endmodule

// File: tb/tb_barrett_reduction_q3329.sv
// tb_barrett_reduction_q3329
//   Self-checking bench: reference model tracks every sampled input for three
//   edges, discards everything on reset, and predicts out_valid/result with
//   plain c % 3329 arithmetic.
module tb_barrett_reduction_q3329;

    localparam int Q = 3329;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] c = '0;
    logic        out_valid;
    logic [15:0] result;

    int checks = 0;
    int errors = 0;

    logic        win_v [4];
    logic [31:0] win_c [4];
    logic        exp_v = 1'b0;
    logic [15:0] exp_r = '0;

    always #5 clk = ~clk;

    barrett_reduction_q3329 dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .c         (c),
        .out_valid (out_valid),
        .result    (result)
    );

    // Advance one edge and update the model; outputs are stable at #1 after.
    task automatic step();
        @(posedge clk);
        for (int i = 3; i > 0; i--) begin
            win_v[i] = win_v[i-1];
            win_c[i] = win_c[i-1];
        end
        win_v[0] = in_valid && rst_n;
        win_c[0] = c;
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) win_v[i] = 1'b0;
            exp_v = 1'b0;
            exp_r = '0;
        end else begin
            exp_v = win_v[3];
            if (win_v[3]) exp_r = 16'(win_c[3] % 32'(Q));
        end
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        in_valid = 1'b1;
        c = $urandom;
        for (int i = 0; i < 4; i++) begin
            step();
            checks++;
            if (out_valid !== 1'b0 || result !== 16'd0) begin
                errors++;
                $display("[TB] FAIL reset: out_valid=%0b result=%0d, required 0/0", out_valid, result);
            end
        end
        rst_n = 1'b1;
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (out_valid !== exp_v || result !== exp_r) begin
                errors++;
                $display("[TB] FAIL reset_release: out_valid=%0b result=%0d, required %0b/%0d", out_valid, result, exp_v, exp_r);
            end
        end
    endtask

    task automatic test_directed();
        logic [31:0] vals [8] = '{32'd0, 32'd3328, 32'd3329, 32'd6657, 32'd6658,
                                  32'hFFFFFFFF, 32'h12345678, 32'h00000D02};
        logic [15:0] refs [8] = '{16'd0, 16'd3328, 16'd0, 16'd3328, 16'd0,
                                  16'd1352, 16'd791, 16'd1};
        for (int k = 0; k < 8; k++) begin
            in_valid = 1'b1;
            c = vals[k];
            step();
            in_valid = 1'b0;
            c = $urandom;
            for (int d = 1; d <= 3; d++) begin
                step();
                checks++;
                if (out_valid !== exp_v || result !== exp_r) begin
                    errors++;
                    $display("[TB] FAIL directed_cycle: c=%h cycle %0d out_valid=%0b result=%0d, required %0b/%0d", vals[k], d, out_valid, result, exp_v, exp_r);
                end
            end
            checks++;
            if (out_valid !== 1'b1 || result !== refs[k]) begin
                errors++;
                $display("[TB] FAIL directed_value: c=%h out_valid=%0b result=%0d, required 1/%0d", vals[k], out_valid, result, refs[k]);
            end
        end
    endtask

    task automatic test_streaming();
        int high_count = 0;
        for (int i = 0; i < 1003; i++) begin
            in_valid = (i < 1000);
            c = $urandom;
            step();
            if (out_valid === 1'b1) high_count++;
            checks++;
            if (out_valid !== exp_v || result !== exp_r) begin
                errors++;
                $display("[TB] FAIL stream: cycle %0d out_valid=%0b result=%0d, required %0b/%0d", i, out_valid, result, exp_v, exp_r);
            end
        end
        in_valid = 1'b0;
        checks++;
        if (high_count != 1000) begin
            errors++;
            $display("[TB] FAIL stream_count: out_valid high %0d cycles, required 1000", high_count);
        end
    endtask

    task automatic test_bubbles();
        logic pattern [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        logic [15:0] held;
        for (int i = 0; i < 8; i++) begin
            in_valid = (i < 5) ? pattern[i] : 1'b0;
            c = $urandom;
            held = result;
            step();
            checks++;
            if (out_valid !== exp_v || result !== exp_r) begin
                errors++;
                $display("[TB] FAIL bubble: cycle %0d out_valid=%0b result=%0d, required %0b/%0d", i, out_valid, result, exp_v, exp_r);
            end
            if (i >= 3) begin
                checks++;
                if (out_valid !== pattern[i-3]) begin
                    errors++;
                    $display("[TB] FAIL bubble_pattern: cycle %0d out_valid=%0b, required %0b", i, out_valid, pattern[i-3]);
                end
                if (!pattern[i-3]) begin
                    checks++;
                    if (result !== held) begin
                        errors++;
                        $display("[TB] FAIL bubble_hold: cycle %0d result=%0d, required %0d", i, result, held);
                    end
                end
            end
        end
    endtask

    task automatic test_reset_midflight();
        for (int i = 0; i < 10; i++) begin
            in_valid = (i < 2);
            rst_n = !(i == 3 || i == 4);
            c = $urandom;
            step();
            checks++;
            if (out_valid !== 1'b0) begin
                errors++;
                $display("[TB] FAIL midflight_valid: cycle %0d out_valid=%0b, required 0", i, out_valid);
            end
            checks++;
            if (out_valid !== exp_v || result !== exp_r) begin
                errors++;
                $display("[TB] FAIL midflight: cycle %0d out_valid=%0b result=%0d, required %0b/%0d", i, out_valid, result, exp_v, exp_r);
            end
        end
        rst_n = 1'b1;
        in_valid = 1'b0;
    endtask

    task automatic test_reset_held();
        logic [31:0] sample;
        rst_n = 1'b0;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            c = $urandom;
            step();
            checks++;
            if (out_valid !== 1'b0 || result !== 16'd0) begin
                errors++;
                $display("[TB] FAIL reset_held: cycle %0d out_valid=%0b result=%0d, required 0/0", i, out_valid, result);
            end
        end
        rst_n = 1'b1;
        sample = $urandom;
        c = sample;
        step();
        in_valid = 1'b0;
        for (int d = 1; d <= 3; d++) begin
            step();
            checks++;
            if (out_valid !== exp_v || result !== exp_r) begin
                errors++;
                $display("[TB] FAIL reset_held_release: cycle %0d out_valid=%0b result=%0d, required %0b/%0d", d, out_valid, result, exp_v, exp_r);
            end
        end
        checks++;
        if (out_valid !== 1'b1 || result !== 16'(sample % 32'(Q))) begin
            errors++;
            $display("[TB] FAIL reset_held_value: out_valid=%0b result=%0d, required 1/%0d", out_valid, result, sample % 32'(Q));
        end
    endtask

    initial begin
        for (int i = 0; i < 4; i++) begin
            win_v[i] = 1'b0;
            win_c[i] = '0;
        end
        $display("[TB] starting barrett_reduction_q3329 bench");
        test_reset();
        test_directed();
        test_streaming();
        test_bubbles();
        test_reset_midflight();
        test_reset_held();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
